// File: rtl/i2s_rx_deserializer_if.sv
// Bundle of the codec-side I2S lines and the parallel line-in sample outputs.
// master drives the serial lines (codec or model); slave is the deserializer.
interface i2s_rx_deserializer_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic                           i2s_bclk;
  logic                           i2s_lr;
  logic                           i2s_din;
  logic signed [SAMPLE_WIDTH-1:0] left_sample;
  logic signed [SAMPLE_WIDTH-1:0] right_sample;
  logic                           sample_valid;
  logic                           frame_error;

  modport master (
    output i2s_bclk, i2s_lr, i2s_din,
    input  left_sample, right_sample, sample_valid, frame_error
  );

  modport slave (
    input  i2s_bclk, i2s_lr, i2s_din,
    output left_sample, right_sample, sample_valid, frame_error
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: oversamples BCLK/LRCLK/DIN in the system clock domain and
// publishes left/right line-in words as a pair with a one-cycle valid strobe.
module i2s_rx_deserializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input logic                  clk,
  input logic                  reset,
  i2s_rx_deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    SHIFT_L,
    SHIFT_R,
    HOLD_L,
    HOLD_R
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] bclk_sync_p0;
  logic [SYNC_STAGES-1:0] lr_sync_p0;
  logic [SYNC_STAGES-1:0] din_sync_p0;
  logic                   bclk_p1;

  logic bclk_s;
  logic lr_s;
  logic din_s;
  logic bclk_rise;
  logic lr_edge;

  logic                           lr_prev;
  logic [CNT_W-1:0]               bit_cnt;
  logic signed [SAMPLE_WIDTH-1:0] shift_reg;
  logic signed [SAMPLE_WIDTH-1:0] left_hold;
  logic signed [SAMPLE_WIDTH-1:0] word_next;
  logic                           left_ok;

  // Stage p0: identical-depth synchronizers so din and lr stay aligned with bclk
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_p0 <= '0;
      lr_sync_p0   <= '0;
      din_sync_p0  <= '0;
      bclk_p1      <= 1'b0;
    end else begin
      bclk_sync_p0 <= (bclk_sync_p0 << 1) | SYNC_STAGES'(bus.i2s_bclk);
      lr_sync_p0   <= (lr_sync_p0 << 1)   | SYNC_STAGES'(bus.i2s_lr);
      din_sync_p0  <= (din_sync_p0 << 1)  | SYNC_STAGES'(bus.i2s_din);
      bclk_p1      <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync_p0[SYNC_STAGES-1];
  assign lr_s      = lr_sync_p0[SYNC_STAGES-1];
  assign din_s     = din_sync_p0[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_p1;
  assign lr_edge   = lr_s ^ lr_prev;
  assign word_next = {shift_reg[SAMPLE_WIDTH-2:0], din_s};

  // Stage p1: frame FSM, advanced only on synchronized BCLK rising edges
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      lr_prev          <= 1'b0;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      left_hold        <= '0;
      left_ok          <= 1'b0;
      bus.left_sample  <= '0;
      bus.right_sample <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_error  <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.frame_error  <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lr_s;
        unique case (state)
          IDLE: state <= HUNT;

          HUNT: begin
            if (lr_edge && !lr_s) begin
              bit_cnt <= '0;
              state   <= SHIFT_L;
            end
          end

          SHIFT_L, SHIFT_R: begin
            if (bit_cnt == LAST_BIT) begin
              // The LSB of an exactly-full slot arrives on the rise that also
              // carries the next slot's LR edge, so this is not a short slot.
              shift_reg <= word_next;
              if (state == SHIFT_L) begin
                left_hold <= word_next;
                left_ok   <= 1'b1;
              end else begin
                if (left_ok) begin
                  bus.left_sample  <= left_hold;
                  bus.right_sample <= word_next;
                  bus.sample_valid <= 1'b1;
                end
                left_ok <= 1'b0;
              end
              if (lr_edge) begin
                bit_cnt <= '0;
                state   <= lr_s ? SHIFT_R : SHIFT_L;
              end else begin
                state <= (state == SHIFT_L) ? HOLD_L : HOLD_R;
              end
            end else if (lr_edge) begin
              bus.frame_error <= 1'b1;
              left_ok         <= 1'b0;
              bit_cnt         <= '0;
              state           <= lr_s ? HUNT : SHIFT_L;
            end else begin
              shift_reg <= word_next;
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end

          HOLD_L, HOLD_R: begin
            if (lr_edge) begin
              bit_cnt <= '0;
              state   <= lr_s ? SHIFT_R : SHIFT_L;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench: drives I2S bit streams into 24-bit and 16-bit deserializers and scoreboards
// the published pairs against a slot-level reference model of the serial stream.
module tb_i2s_rx_deserializer;

  localparam int HALF_BCLK = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk = 1'b0;
  logic lr = 1'b0;
  logic din = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  i2s_rx_deserializer_if #(.SAMPLE_WIDTH(24)) bus24 ();
  i2s_rx_deserializer_if #(.SAMPLE_WIDTH(16)) bus16 ();

  assign bus24.i2s_bclk = bclk & ~sel;
  assign bus24.i2s_lr   = lr;
  assign bus24.i2s_din  = din;
  assign bus16.i2s_bclk = bclk & sel;
  assign bus16.i2s_lr   = lr;
  assign bus16.i2s_din  = din;

  i2s_rx_deserializer #(.SAMPLE_WIDTH(24), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .reset(reset), .bus(bus24)
  );
  i2s_rx_deserializer #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Stream: one entry per BCLK period; b_q holds the slot bit launched one period later.
  bit lr_q[$];
  bit b_q[$];
  logic [23:0] exp_l24[$], exp_r24[$], exp_l16[$], exp_r16[$];

  function automatic bit din_at(input int p);
    return (p == 0) ? 1'b0 : b_q[p-1];
  endfunction

  task automatic clear_stream();
    lr_q.delete();
    b_q.delete();
  endtask

  task automatic add_slot(input bit lrv, input int len, input logic [23:0] word, input int w);
    for (int j = 0; j < len; j++) begin
      lr_q.push_back(lrv);
      b_q.push_back((j < w) ? word[w-1-j] : 1'($urandom()));
    end
  endtask

  task automatic add_frame(input logic [23:0] l, input logic [23:0] r, input int slot, input int w);
    add_slot(1'b0, slot, l, w);
    add_slot(1'b1, slot, r, w);
  endtask

  // Reference: walk LR slots; a locked slot yields a word if W bits fit before its end.
  task automatic run_model(input int w, input bit s16, output int n_pairs, output int n_err);
    int edges[$];
    int n;
    bit locked;
    bit left_ok;
    logic [23:0] left_w;
    logic [23:0] word;
    n = lr_q.size();
    locked = 1'b0;
    left_ok = 1'b0;
    left_w = '0;
    n_pairs = 0;
    n_err = 0;
    for (int p = 1; p < n; p++) if (lr_q[p] != lr_q[p-1]) edges.push_back(p);
    for (int i = 0; i < edges.size(); i++) begin
      int e;
      int e2;
      e  = edges[i];
      e2 = (i + 1 < edges.size()) ? edges[i+1] : n;
      if (!locked) begin
        if (lr_q[e]) continue;
        locked = 1'b1;
      end
      if (e + w < n && e + w <= e2) begin
        word = '0;
        for (int j = 1; j <= w; j++) word = {word[22:0], din_at(e + j)};
        if (!lr_q[e]) begin
          left_w  = word;
          left_ok = 1'b1;
        end else begin
          if (left_ok) begin
            n_pairs++;
            if (s16) begin exp_l16.push_back(left_w); exp_r16.push_back(word); end
            else     begin exp_l24.push_back(left_w); exp_r24.push_back(word); end
          end
          left_ok = 1'b0;
        end
      end else if (e2 < n) begin
        n_err++;
        left_ok = 1'b0;
        if (lr_q[e2]) locked = 1'b0;
      end
    end
  endtask

  task automatic play();
    for (int p = 0; p < lr_q.size(); p++) begin
      @(negedge clk);
      bclk = 1'b0;
      lr   = lr_q[p];
      din  = din_at(p);
      repeat (HALF_BCLK) @(negedge clk);
      bclk = 1'b1;
      repeat (HALF_BCLK - 1) @(negedge clk);
    end
    @(negedge clk);
    bclk = 1'b0;
    repeat (HALF_BCLK) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Monitors: pop the scoreboard whenever a DUT presents a pair
  int vld24 = 0, err24 = 0, vld16 = 0, err16 = 0;
  int vld_cyc24[$];
  logic [23:0] last_l24, last_r24, prev_l24, prev_r24;
  logic [15:0] last_l16, last_r16, prev_l16, prev_r16;

  always @(negedge clk) begin
    logic [23:0] el, er;
    if (reset) begin
      last_l24 = '0;
      last_r24 = '0;
    end else begin
      if (bus24.frame_error) begin
        err24++;
        check("excl24", {31'h0, bus24.sample_valid}, 32'h0);
      end
      if (bus24.sample_valid) begin
        vld24++;
        vld_cyc24.push_back(cyc);
        check("hold_l24", {8'h0, prev_l24}, {8'h0, last_l24});
        check("hold_r24", {8'h0, prev_r24}, {8'h0, last_r24});
        check("expected24", {31'h0, exp_l24.size() > 0}, 32'h1);
        if (exp_l24.size() > 0) begin
          el = exp_l24.pop_front();
          er = exp_r24.pop_front();
          check("left24", {8'h0, bus24.left_sample}, {8'h0, el});
          check("right24", {8'h0, bus24.right_sample}, {8'h0, er});
          last_l24 = el;
          last_r24 = er;
        end
      end
    end
    prev_l24 = bus24.left_sample;
    prev_r24 = bus24.right_sample;
  end

  always @(negedge clk) begin
    logic [23:0] el, er;
    if (reset) begin
      last_l16 = '0;
      last_r16 = '0;
    end else begin
      if (bus16.frame_error) begin
        err16++;
        check("excl16", {31'h0, bus16.sample_valid}, 32'h0);
      end
      if (bus16.sample_valid) begin
        vld16++;
        check("hold_l16", {16'h0, prev_l16}, {16'h0, last_l16});
        check("expected16", {31'h0, exp_l16.size() > 0}, 32'h1);
        if (exp_l16.size() > 0) begin
          el = exp_l16.pop_front();
          er = exp_r16.pop_front();
          check("left16", {16'h0, bus16.left_sample}, {8'h0, el});
          check("right16", {16'h0, bus16.right_sample}, {8'h0, er});
          last_l16 = el[15:0];
          last_r16 = er[15:0];
        end
      end
    end
    prev_l16 = bus16.left_sample;
    prev_r16 = bus16.right_sample;
  end

  initial begin
    int v0, e0, np, ne;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_left", {8'h0, bus24.left_sample}, 32'h0);
    check("rst_right", {8'h0, bus24.right_sample}, 32'h0);
    check("rst_valid", {31'h0, bus24.sample_valid}, 32'h0);
    check("rst_ferr", {31'h0, bus24.frame_error}, 32'h0);

    // 1: single 32-bit-slot frame
    v0 = vld24; e0 = err24;
    clear_stream();
    add_slot(1'b1, 4, 24'h0, 24);
    add_frame(24'h123456, 24'hABCDEF, 32, 24);
    add_slot(1'b0, 2, 24'h0, 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("t1_valids", vld24 - v0, 1);
    check("t1_errors", err24 - e0, 0);

    // 2: reset released mid right slot
    lr = 1'b1;
    do_reset();
    v0 = vld24; e0 = err24;
    clear_stream();
    add_slot(1'b1, 10, 24'($urandom()), 24);
    add_frame(24'($urandom()), 24'($urandom()), 32, 24);
    add_slot(1'b0, 2, 24'h0, 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("t2_valids", vld24 - v0, 1);
    check("t2_errors", err24 - e0, 0);

    // 3: left slot cut after 10 bits, then a good frame
    do_reset();
    v0 = vld24; e0 = err24;
    clear_stream();
    add_slot(1'b1, 4, 24'h0, 24);
    add_slot(1'b0, 11, 24'($urandom()), 24);
    add_slot(1'b1, 32, 24'($urandom()), 24);
    add_frame(24'h000001, 24'hFFFFFF, 32, 24);
    add_slot(1'b0, 2, 24'h0, 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("t3_valids", vld24 - v0, 1);
    check("t3_errors", err24 - e0, 1);

    // 4: reset pulse while shifting a right word
    do_reset();
    v0 = vld24;
    clear_stream();
    add_slot(1'b1, 4, 24'h0, 24);
    add_frame(24'h5A5A5A, 24'hA5A5A5, 32, 24);
    add_slot(1'b0, 32, 24'($urandom()), 24);
    add_slot(1'b1, 13, 24'($urandom()), 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("t4_valids_pre", vld24 - v0, 1);
    do_reset();
    @(negedge clk);
    check("t4_rst_left", {8'h0, bus24.left_sample}, 32'h0);
    check("t4_rst_right", {8'h0, bus24.right_sample}, 32'h0);
    check("t4_rst_valid", {31'h0, bus24.sample_valid}, 32'h0);
    v0 = vld24;
    clear_stream();
    add_slot(1'b1, 4, 24'h0, 24);
    add_frame(24'h0F0F0F, 24'hF0F0F0, 32, 24);
    add_slot(1'b0, 2, 24'h0, 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("t4_valids_post", vld24 - v0, 1);

    // 5: four back-to-back frames, pulses 64 BCLK periods apart
    do_reset();
    v0 = vld24;
    vld_cyc24.delete();
    clear_stream();
    add_slot(1'b1, 4, 24'h0, 24);
    for (int f = 0; f < 4; f++) add_frame(24'h800000, 24'h7FFFFF, 32, 24);
    add_slot(1'b0, 2, 24'h0, 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("t5_valids", vld24 - v0, 4);
    for (int k = 1; k < vld_cyc24.size(); k++)
      check("t5_spacing", vld_cyc24[k] - vld_cyc24[k-1], 64 * 2 * HALF_BCLK);

    // Random slot lengths, occasional short slots, random lead-in
    do_reset();
    v0 = vld24; e0 = err24;
    clear_stream();
    if ($urandom_range(1) == 1) add_slot(1'b0, $urandom_range(20, 3), 24'($urandom()), 24);
    add_slot(1'b1, $urandom_range(20, 3), 24'($urandom()), 24);
    for (int f = 0; f < 8; f++) begin
      add_slot(1'b0, ($urandom_range(5) == 0) ? $urandom_range(23, 2) : $urandom_range(32, 24),
               24'($urandom()), 24);
      add_slot(1'b1, ($urandom_range(7) == 0) ? $urandom_range(23, 2) : $urandom_range(32, 24),
               24'($urandom()), 24);
    end
    add_slot(1'b0, 2, 24'h0, 24);
    run_model(24, 1'b0, np, ne);
    play();
    check("rand_valids", vld24 - v0, np);
    check("rand_errors", err24 - e0, ne);
    check("pending24", exp_l24.size(), 0);

    // 6: 16-bit instance with exactly 16-bit slots
    sel = 1'b1;
    do_reset();
    v0 = vld16; e0 = err16;
    clear_stream();
    add_slot(1'b1, 4, 24'h0, 16);
    add_frame(24'h00BEEF, 24'h001234, 16, 16);
    add_frame({8'h0, 16'($urandom())}, {8'h0, 16'($urandom())}, 16, 16);
    add_slot(1'b0, 2, 24'h0, 16);
    run_model(16, 1'b1, np, ne);
    play();
    check("t6_valids", vld16 - v0, 2);
    check("t6_errors", err16 - e0, 0);
    check("pending16", exp_l16.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
